// File: rtl/neuron_weighted_sum_if.sv
// Beat/result handshake bundle for neuron_weighted_sum.
// The slave modport is the neuron's view; the master modport is the upstream/downstream driver's view.
interface neuron_weighted_sum_if #(
  parameter int voltage_size = 24,
  parameter int input_size   = 12,
  parameter int weight_size  = 12,
  parameter int bias_size    = 6
);
  logic                           in_valid;
  logic                           in_ready;
  logic signed [input_size-1:0]   input_sample;
  logic signed [weight_size-1:0]  weight;
  logic signed [bias_size-1:0]    bias_in;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [voltage_size-2:0] sum_weights_into_inputs;
  logic signed [bias_size-1:0]    bias;
  logic                           overflow;

  modport slave (
    input  in_valid, input_sample, weight, bias_in, out_ready,
    output in_ready, out_valid, sum_weights_into_inputs, bias, overflow
  );

  modport master (
    output in_valid, input_sample, weight, bias_in, out_ready,
    input  in_ready, out_valid, sum_weights_into_inputs, bias, overflow
  );
endinterface

// File: rtl/neuron_weighted_sum.sv
// Multiply-accumulate of num_inputs signed (sample, weight) beats with a latched bias.
// Define NEURON_SUM_SATURATE_EN to clamp out-of-range sums instead of wrapping them.
//
// state   | meaning
// IDLE    | waiting for the first beat of an evaluation
// ACCUM   | accumulating beats 2..num_inputs
// DONE    | result valid, held until out_ready
module neuron_weighted_sum #(
  parameter int voltage_size = 24,
  parameter int input_size   = 12,
  parameter int weight_size  = 12,
  parameter int bias_size    = 6,
  parameter int num_inputs   = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  neuron_weighted_sum_if.slave bus
);

  localparam int ACC_W  = voltage_size + 4;
  localparam int PROD_W = input_size + weight_size;
  localparam int OUT_W  = voltage_size - 1;
  localparam int CNT_W  = $clog2(num_inputs + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-voltage_size+2){1'b0}}, {(voltage_size-2){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic [1:0]                    r_state;
  logic signed [ACC_W-1:0]       r_acc;
  logic [CNT_W-1:0]              r_count;
  logic signed [bias_size-1:0]   r_bias_lat;
  logic signed [OUT_W-1:0]       r_sum;
  logic signed [bias_size-1:0]   r_bias;
  logic                          r_ovf;

  logic signed [PROD_W-1:0]      w_product;
  logic signed [ACC_W-1:0]       w_prod_ext;
  logic signed [ACC_W-1:0]       w_acc_next;
  logic [CNT_W-1:0]              w_cnt_next;
  logic                          w_first;
  logic                          w_beat;
  logic                          w_last;
  logic                          w_ovf;
  logic signed [OUT_W-1:0]       w_sum_next;

  assign bus.in_ready = reset_n && ((r_state == S_IDLE) || (r_state == S_ACCUM));
  assign w_beat       = bus.in_valid && bus.in_ready;
  assign w_first      = (r_state == S_IDLE);

  assign w_product  = bus.input_sample * bus.weight;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_product[PROD_W-1]}}, w_product};
  assign w_acc_next = w_first ? w_prod_ext : r_acc + w_prod_ext;
  assign w_cnt_next = w_first ? CNT_W'(1) : r_count + CNT_W'(1);
  assign w_last     = (w_cnt_next == CNT_W'(num_inputs));
  assign w_ovf      = (w_acc_next > MAX_V) || (w_acc_next < MIN_V);

`ifdef NEURON_SUM_SATURATE_EN
  always_comb begin
    w_sum_next = w_acc_next[OUT_W-1:0];
    if (w_acc_next > MAX_V)      w_sum_next = MAX_V[OUT_W-1:0];
    else if (w_acc_next < MIN_V) w_sum_next = MIN_V[OUT_W-1:0];
  end
`else
  assign w_sum_next = w_acc_next[OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_count    <= '0;
      r_bias_lat <= '0;
      r_sum      <= '0;
      r_bias     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_beat) begin
            r_acc   <= w_acc_next;
            r_count <= w_cnt_next;
            if (w_first) r_bias_lat <= bus.bias_in;
            if (w_last) begin
              r_state <= S_DONE;
              r_sum   <= w_sum_next;
              r_ovf   <= w_ovf;
              // single-beat evaluations never see the latch, so take bias_in directly
              r_bias  <= w_first ? bus.bias_in : r_bias_lat;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid               = (r_state == S_DONE);
  assign bus.sum_weights_into_inputs = r_sum;
  assign bus.bias                    = r_bias;
  assign bus.overflow                = r_ovf;

endmodule

// File: tb/tb_neuron_weighted_sum.sv
// Randomized and directed checks of neuron_weighted_sum against an arithmetic reference model.
// Define NEURON_SUM_SATURATE_EN for both bench and RTL to check the clamping build.
module tb_neuron_weighted_sum;
  localparam int  N       = 8;
  localparam longint OUT_MAX = 4194303;
  localparam longint OUT_MIN = -4194304;
  localparam longint MOD     = 8388608;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   tx[N];
  int   tw[N];

  neuron_weighted_sum_if bus ();

  neuron_weighted_sum dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(output longint s, output bit ovf);
    longint acc = 0;
    for (int i = 0; i < N; i++) acc += longint'(tx[i]) * longint'(tw[i]);
    ovf = (acc > OUT_MAX) || (acc < OUT_MIN);
`ifdef NEURON_SUM_SATURATE_EN
    s = (acc > OUT_MAX) ? OUT_MAX : (acc < OUT_MIN) ? OUT_MIN : acc;
`else
    s = acc % MOD;
    if (s < 0) s += MOD;
    if (s > OUT_MAX) s -= MOD;
`endif
  endfunction

  task automatic send_beat(input int x, input int w, input int b);
    int t = 0;
    bus.input_sample = x[11:0];
    bus.weight       = w[11:0];
    bus.bias_in      = b[5:0];
    bus.in_valid     = 1'b1;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: in_ready got %b expected 1 within 50 cycles", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_eval(input int gap_mode, input int b, input int stall,
                          input string name, output longint obs);
    longint exp_s, os;
    bit     exp_o;
    int     ob, g;
    model(exp_s, exp_o);
    for (int i = 0; i < N; i++) begin
      g = (i == 0) ? 0 : (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (g) begin
        bus.input_sample = 12'($urandom);
        bus.weight       = 12'($urandom);
        @(posedge clk); #1;
      end
      if (i == N - 1) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s early_valid: got %b expected 0", name, bus.out_valid);
        end
      end
      send_beat(tx[i], tw[i], (i == 0) ? b : int'($urandom_range(0, 63)) - 32);
    end
    os  = bus.sum_weights_into_inputs;
    ob  = bus.bias;
    obs = os;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: out_valid got %b expected 1", name, bus.out_valid);
    end
    checks++;
    if (os !== exp_s) begin
      errors++;
      $display("FAIL %s sum: got %0d expected %0d", name, os, exp_s);
    end
    checks++;
    if (ob !== b) begin
      errors++;
      $display("FAIL %s bias: got %0d expected %0d", name, ob, b);
    end
    checks++;
    if (bus.overflow !== exp_o) begin
      errors++;
      $display("FAIL %s overflow: got %b expected %b", name, bus.overflow, exp_o);
    end
    bus.out_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
      os = bus.sum_weights_into_inputs;
      ob = bus.bias;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || os !== exp_s ||
          ob !== b || bus.overflow !== exp_o) begin
        errors++;
        $display("FAIL %s stall: valid %b ready %b sum %0d bias %0d ovf %b expected 1 0 %0d %0d %b",
                 name, bus.out_valid, bus.in_ready, os, ob, bus.overflow, exp_s, b, exp_o);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    os = bus.sum_weights_into_inputs;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || os !== exp_s) begin
      errors++;
      $display("FAIL %s release: valid %b ready %b sum %0d expected 0 1 %0d",
               name, bus.out_valid, bus.in_ready, os, exp_s);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum_weights_into_inputs !== '0 ||
        bus.bias !== '0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid %b sum %0d bias %0d ovf %b expected all 0",
               bus.out_valid, bus.sum_weights_into_inputs, bus.bias, bus.overflow);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    longint s;
    for (int i = 0; i < N; i++) begin tx[i] = 1; tw[i] = 1; end
    run_eval(0, 3, 0, "basic", s);
    checks++;
    if (s !== 8) begin
      errors++;
      $display("FAIL basic_const: got %0d expected 8", s);
    end
  endtask

  task automatic test_overflow();
    longint s;
    for (int i = 0; i < N; i++) begin tx[i] = 2047; tw[i] = 2047; end
    run_eval(0, -5, 0, "ovf_pos", s);
    checks++;
`ifdef NEURON_SUM_SATURATE_EN
    if (s !== 4194303) begin
      errors++;
      $display("FAIL ovf_pos_const: got %0d expected 4194303", s);
    end
`else
    if (s !== -32760) begin
      errors++;
      $display("FAIL ovf_pos_const: got %0d expected -32760", s);
    end
`endif
    for (int i = 0; i < N; i++) begin tx[i] = -2048; tw[i] = 2047; end
    run_eval(0, 31, 0, "ovf_neg", s);
    checks++;
`ifdef NEURON_SUM_SATURATE_EN
    if (s !== -4194304) begin
      errors++;
      $display("FAIL ovf_neg_const: got %0d expected -4194304", s);
    end
`else
    if (s !== 16384) begin
      errors++;
      $display("FAIL ovf_neg_const: got %0d expected 16384", s);
    end
`endif
  endtask

  task automatic test_stall();
    longint s;
    for (int i = 0; i < N; i++) begin tx[i] = i - 3; tw[i] = 100 * i; end
    run_eval(0, -32, 5, "stall", s);
  endtask

  task automatic test_reset_mid();
    longint s;
    for (int i = 0; i < 3; i++) send_beat(5, 5, 7);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b expected 0", bus.in_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum_weights_into_inputs !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: ready %b valid %b sum %0d expected 1 0 0",
               bus.in_ready, bus.out_valid, bus.sum_weights_into_inputs);
    end
    for (int i = 0; i < N; i++) begin tx[i] = 1; tw[i] = 2; end
    run_eval(0, 1, 0, "after_reset", s);
    checks++;
    if (s !== 16) begin
      errors++;
      $display("FAIL after_reset_const: got %0d expected 16", s);
    end
  endtask

  task automatic test_gaps();
    longint s;
    for (int i = 0; i < N; i++) begin tx[i] = 3; tw[i] = -4; end
    run_eval(1, -1, 0, "gaps", s);
    checks++;
    if (s !== -96) begin
      errors++;
      $display("FAIL gaps_const: got %0d expected -96", s);
    end
  endtask

  task automatic test_random();
    longint s;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) begin
        tx[i] = int'($urandom_range(0, 4095)) - 2048;
        tw[i] = int'($urandom_range(0, 4095)) - 2048;
      end
      run_eval(2, int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 3)), "random", s);
    end
  endtask

  task automatic test_back_to_back();
    longint s;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        tx[i] = int'($urandom_range(0, 200)) - 100;
        tw[i] = int'($urandom_range(0, 200)) - 100;
      end
      run_eval(0, k, 0, "back_to_back", s);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    bus.in_valid     = 1'b0;
    bus.input_sample = '0;
    bus.weight       = '0;
    bus.bias_in      = '0;
    bus.out_ready    = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_gaps();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/neuron_weighted_sum.md
NEURON_WEIGHTED_SUM -- requirements
Module: neuron_weighted_sum

Interface
REQ-001 SHALL have parameter voltage_size, default 24, setting the summed-voltage width; the output sum is voltage_size-1 bits.
REQ-002 SHALL have parameter input_size, default 12, the signed input-sample width.
REQ-003 SHALL have parameter weight_size, default 12, the signed weight width.
REQ-004 SHALL have parameter bias_size, default 6, the signed bias width.
REQ-005 SHALL have parameter num_inputs, default 8, the beats per neuron evaluation; legal range 1..16.
REQ-006 SHALL have one clock and a synchronous, active-low reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset_n  input  1  synchronous active-low reset.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  block accepts a beat.
REQ-011 input_sample  input  input_size  signed sample.
REQ-012 weight  input  weight_size  signed weight paired with input_sample.
REQ-013 bias_in  input  bias_size  signed bias, sampled on the first beat.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream activation stage accepts the result.
REQ-016 sum_weights_into_inputs  output  voltage_size-1  signed weighted sum.
REQ-017 bias  output  bias_size  signed bias latched for this evaluation.
REQ-018 overflow  output  1  accumulator exceeded the output range.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-020 A beat SHALL transfer only on a rising edge with in_valid=1 and in_ready=1.
REQ-021 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-022 IDLE on a beat: acc=product, bias latched from bias_in, count=1; next state ACCUM, or DONE if num_inputs=1.
REQ-023 ACCUM on a beat: acc=acc+product, count+1; when count reaches num_inputs, next state DONE.
REQ-024 The product SHALL be a full-precision signed input_size+weight_size bit value; acc SHALL be a signed voltage_size+4 bit value and SHALL never wrap internally.
REQ-025 out_valid SHALL be 1 only in DONE, starting the cycle after the final beat is accepted; latency is 1 cycle.
REQ-026 In DONE, sum_weights_into_inputs, bias and overflow SHALL remain stable until out_ready=1.
REQ-027 DONE with out_ready=1: next state IDLE, acc and count cleared, outputs held at their last values; out_valid falls the next cycle.
REQ-028 overflow SHALL be 1 when acc is outside [-2^(voltage_size-2), 2^(voltage_size-2)-1], and 0 otherwise.
REQ-029 in_valid=0 in ACCUM SHALL hold state, acc and count unchanged; the inter-beat gap is unbounded.

Reset
REQ-030 With reset_n=0 at a clock edge: state=IDLE, acc=0, count=0, out_valid=0, sum_weights_into_inputs=0, bias=0, overflow=0; in_ready SHALL be 0 while reset_n=0.
REQ-031 Reset mid-evaluation SHALL discard partial sums; the next evaluation starts fresh from beat 0.

Configuration
REQ-032 With macro NEURON_SUM_SATURATE_EN defined, an out-of-range acc SHALL produce sum_weights_into_inputs clamped to 2^(voltage_size-2)-1 or -2^(voltage_size-2).
REQ-033 Without NEURON_SUM_SATURATE_EN, sum_weights_into_inputs SHALL be the low voltage_size-1 bits of acc (two's-complement wrap); overflow is still reported.

Verification
REQ-034 Defaults; 8 beats of x=1, w=1, bias_in=3 -> out_valid 1 cycle after beat 8; sum=8, bias=3, overflow=0.
REQ-035 8 beats of x=2047, w=2047 -> overflow=1; sum=4194303 with SATURATE_EN, or -32760 without it.
REQ-036 8 beats of x=-2048, w=2047 with SATURATE_EN -> sum=-4194304, overflow=1.
REQ-037 Result ready, out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-038 reset_n=0 for 1 cycle after 3 beats of x=5, w=5 -> IDLE with acc=0; then 8 beats of x=1, w=2 -> sum=16.
REQ-039 in_valid toggling 1/0 every cycle over 8 beats of x=3, w=-4 -> sum=-96 after the 8th accepted beat.
